// File: rtl/nios_mul_seq_if.sv
// Request/result handshake bundle for the Nios II multiply sequencer.
// The master issues operations and consumes results; the slave is the sequencer.
interface nios_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/nios_mul_seq.sv
// Multi-pass multiply sequencer around the 16x16 three-partial-product cell.
// MUL uses one cell pass; MULX* adds an ah*bh pass and a signed correction.
module nios_mul_seq #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  nios_mul_seq_if.slave bus,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE, ISSUE0, WAIT0, SUM0, ISSUE1, WAIT1, SUM1, FIX, DONE
  } state_e;

  localparam bit HAS_WAIT = (CELL_LATENCY > 1);
  localparam int CNT_W    = (CELL_LATENCY > 2) ? $clog2(CELL_LATENCY - 1) : 1;
  // WAIT runs CELL_LATENCY-1 cycles, so the counter is preloaded with one less.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((CELL_LATENCY > 1) ? CELL_LATENCY - 2 : 0);

  state_e           r_state, w_next;
  op_e              r_op;
  logic [31:0]      r_a, r_b, r_result, r_cell_src1, r_cell_src2;
  logic [63:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic        w_in_ready, w_out_valid, w_cell_en, w_accept;
  logic [32:0] w_mid;
  logic [63:0] w_sum0, w_sum1;
  logic [31:0] w_hi, w_corr_a, w_corr_b, w_fixed;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_cell_en   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ISSUE0;
      end
      ISSUE0: begin
        w_cell_en = 1'b1;
        w_next    = HAS_WAIT ? WAIT0 : SUM0;
      end
      WAIT0:  if (r_cnt == '0) w_next = SUM0;
      SUM0:   w_next = (r_op == OP_MUL) ? DONE : ISSUE1;
      ISSUE1: begin
        w_cell_en = 1'b1;
        w_next    = HAS_WAIT ? WAIT1 : SUM1;
      end
      WAIT1:  if (r_cnt == '0) w_next = SUM1;
      SUM1:   w_next = FIX;
      FIX:    w_next = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // Cross terms are summed at 33 bits so their carry reaches bit 48 of the product.
  assign w_mid  = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign w_sum0 = {32'h0, cell_p1} + ({31'h0, w_mid} << 16);
  assign w_sum1 = r_acc + {cell_p1, 32'h0};

  // Signed high word: subtract b (or a) shifted by 32 for each negative signed operand.
  assign w_hi     = r_acc[63:32];
  assign w_corr_a = (r_a[31] && (r_op == OP_MULXSU || r_op == OP_MULXSS)) ? r_b : 32'h0;
  assign w_corr_b = (r_b[31] && (r_op == OP_MULXSS)) ? r_a : 32'h0;
  assign w_fixed  = w_hi - w_corr_a - w_corr_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_MUL;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_cell_src1 <= '0;
      r_cell_src2 <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op        <= op_e'(bus.in_op);
          r_a         <= bus.in_a;
          r_b         <= bus.in_b;
          r_cell_src1 <= bus.in_a;
          r_cell_src2 <= bus.in_b;
        end
        ISSUE0, ISSUE1: r_cnt <= WAIT_LOAD;
        WAIT0, WAIT1:   r_cnt <= r_cnt - 1'b1;
        SUM0: begin
          r_acc       <= w_sum0;
          if (r_op == OP_MUL) r_result <= w_sum0[31:0];
          r_cell_src1 <= {16'h0, r_a[31:16]};
          r_cell_src2 <= {16'h0, r_b[31:16]};
        end
        SUM1: r_acc    <= w_sum1;
        FIX:  r_result <= w_fixed;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = r_result;
  assign cell_en        = w_cell_en;
  assign cell_src1      = r_cell_src1;
  assign cell_src2      = r_cell_src2;

endmodule

// File: tb/tb_nios_mul_seq.sv
// Bench for nios_mul_seq: directed checks on a CELL_LATENCY=1 build and
// random traffic on a CELL_LATENCY=3 build, both against a 64-bit reference.
module tb_nios_mul_seq;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    int          lat;
    int          pulses;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
  } cell_t;

  localparam vec_t VECS [10] = '{
    '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
    '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
    '{2'd3, 32'h80000000, 32'h80000000, 32'h40000000},
    '{2'd2, 32'h80000000, 32'h00000002, 32'hFFFFFFFF},
    '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001},
    '{2'd3, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF},
    '{2'd0, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF},
    '{2'd1, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFE0001}
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rnd_bp;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  nios_mul_seq_if bus_a ();
  nios_mul_seq_if bus_b ();

  logic [31:0] src1_a, src2_a, p1_a, p2_a, p3_a;
  logic [31:0] src1_b, src2_b, p1_b, p2_b, p3_b;
  logic        en_a, en_b;

  nios_mul_seq #(.CELL_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .cell_src1(src1_a), .cell_src2(src2_a), .cell_en(en_a),
    .cell_p1(p1_a), .cell_p2(p2_a), .cell_p3(p3_a)
  );

  nios_mul_seq #(.CELL_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .cell_src1(src1_b), .cell_src2(src2_b), .cell_en(en_b),
    .cell_p1(p1_b), .cell_p2(p2_b), .cell_p3(p3_b)
  );

  // Multiplier cell models: products appear LAT cycles after cell_en and then hold.
  function automatic cell_t cell_calc(input logic en, input logic [31:0] s1, input logic [31:0] s2);
    cell_t c;
    c.v  = en;
    c.p1 = {16'h0, s1[15:0]}  * {16'h0, s2[15:0]};
    c.p2 = {16'h0, s1[15:0]}  * {16'h0, s2[31:16]};
    c.p3 = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
    return c;
  endfunction

  cell_t c_a, d1_b, d2_b;
  initial begin
    p1_a = '0; p2_a = '0; p3_a = '0;
    p1_b = '0; p2_b = '0; p3_b = '0;
    d1_b = '0; d2_b = '0;
  end

  always @(posedge clk) begin
    c_a = cell_calc(en_a, src1_a, src2_a);
    if (c_a.v) begin
      p1_a <= c_a.p1; p2_a <= c_a.p2; p3_a <= c_a.p3;
    end
    d1_b <= cell_calc(en_b, src1_b, src2_b);
    d2_b <= d1_b;
    if (d2_b.v) begin
      p1_b <= d2_b.p1; p2_b <= d2_b.p2; p3_b <= d2_b.p3;
    end
  end

  always @(posedge clk) begin
    #1;
    bus_b.out_ready = rnd_bp ? ($urandom_range(3) != 0) : 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, prod;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'd0:    prod = ua * ub;
      2'd1:    prod = ua * ub;
      2'd2:    prod = sa * ub;
      default: prod = sa * sb;
    endcase
    return (op == 2'd0) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic int exp_latency(input int d, input logic [1:0] op);
    int l;
    l = (d == 0) ? LAT_A : LAT_B;
    return (op == 2'd0) ? 2 + l : 4 + 2 * l;
  endfunction

  // Scoreboard state, one slot per DUT (0: latency 1, 1: latency 3).
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t cur[2];
  int   acc_cyc[2];
  int   pulse_cnt[2];
  logic busy[2];
  logic prev_ov[2];

  function automatic int sb_size(input int d);
    return (d == 0) ? sb_a.size() : sb_b.size();
  endfunction

  task automatic push_exp(input int d, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res);
    exp_t e;
    e.a = a; e.b = b; e.result = res;
    e.lat    = exp_latency(d, op);
    e.pulses = (op == 2'd0) ? 1 : 2;
    if (d == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
  endtask

  task automatic mon(input int d, input logic rst, input logic iv, input logic ir,
                     input logic ov, input logic ordy, input logic [31:0] res,
                     input logic en, input logic [31:0] s1, input logic [31:0] s2);
    exp_t  e;
    string p;
    p = (d == 0) ? "L1 " : "L3 ";
    if (rst) begin
      if (d == 0) sb_a.delete();
      else        sb_b.delete();
      busy[d] = 1'b0; pulse_cnt[d] = 0; prev_ov[d] = 1'b0;
      return;
    end
    if (iv && ir) begin
      busy[d] = 1'b1; acc_cyc[d] = cyc; pulse_cnt[d] = 0;
      if (sb_size(d) > 0) cur[d] = (d == 0) ? sb_a[0] : sb_b[0];
    end
    if (en) begin
      if (!busy[d]) check({p, "cell_en_while_idle"}, en, 0);
      else if (pulse_cnt[d] == 0) begin
        check({p, "pass0_src1"}, s1, cur[d].a);
        check({p, "pass0_src2"}, s2, cur[d].b);
      end else if (pulse_cnt[d] == 1) begin
        check({p, "pass1_src1"}, s1, {16'h0, cur[d].a[31:16]});
        check({p, "pass1_src2"}, s2, {16'h0, cur[d].b[31:16]});
      end
      pulse_cnt[d]++;
    end
    if (ov && !prev_ov[d]) begin
      if (busy[d]) check({p, "latency"}, cyc - acc_cyc[d], cur[d].lat);
      else         check({p, "out_valid_while_idle"}, ov, 0);
    end
    if (ov && ordy) begin
      if (sb_size(d) == 0) check({p, "unexpected_result"}, ov, 0);
      else begin
        e = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check({p, "result"}, res, e.result);
        check({p, "cell_en_pulses"}, pulse_cnt[d], e.pulses);
      end
      busy[d] = 1'b0;
    end
    prev_ov[d] = ov;
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, bus_a.in_valid, bus_a.in_ready, bus_a.out_valid, bus_a.out_ready,
        bus_a.out_result, en_a, src1_a, src2_a);
    mon(1, rst_b, bus_b.in_valid, bus_b.in_ready, bus_b.out_valid, bus_b.out_ready,
        bus_b.out_result, en_b, src1_b, src2_b);
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res);
    int   waited;
    logic rdy;
    push_exp(d, op, a, b, res);
    if (d == 0) begin
      bus_a.in_valid = 1'b1; bus_a.in_op = op; bus_a.in_a = a; bus_a.in_b = b;
    end else begin
      bus_b.in_valid = 1'b1; bus_b.in_op = op; bus_b.in_a = a; bus_b.in_b = b;
    end
    waited = 0;
    forever begin
      @(negedge clk);
      rdy = (d == 0) ? bus_a.in_ready : bus_b.in_ready;
      if (rdy) break;
      waited++;
      if (waited > 100) begin
        check("accept_timeout", rdy, 1);
        break;
      end
    end
    @(posedge clk); #1;
    if (d == 0) bus_a.in_valid = 1'b0;
    else        bus_b.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int w;
    w = 0;
    while (sb_size(d) != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check((d == 0) ? "L1 drain_pending" : "L3 drain_pending", sb_size(d), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string p, input logic ir, input logic ov, input logic en,
                            input logic [31:0] res, input logic [31:0] s1, input logic [31:0] s2);
    check({p, "rst_in_ready"},  ir,  1);
    check({p, "rst_out_valid"}, ov,  0);
    check({p, "rst_cell_en"},   en,  0);
    check({p, "rst_out_result"}, res, 0);
    check({p, "rst_cell_src1"}, s1,  0);
    check({p, "rst_cell_src2"}, s2,  0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      4:       return {16'h0, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic directed_a();
    int w;
    foreach (VECS[i]) send(0, VECS[i].op, VECS[i].a, VECS[i].b, VECS[i].r);
    wait_drain(0);

    // Abort during ISSUE1 with a two-cycle reset, then run a fresh MUL.
    send(0, 2'd1, 32'h12345678, 32'h9ABCDEF0, ref_mul(2'd1, 32'h12345678, 32'h9ABCDEF0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("L1 issue1_cell_en", en_a, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check_idle("L1 midop ", bus_a.in_ready, bus_a.out_valid, en_a, bus_a.out_result, src1_a, src2_a);
    @(posedge clk); #1;
    send(0, 2'd0, 32'd3, 32'd5, 32'h0000000F);
    wait_drain(0);

    // Backpressure with a second request queued behind a stalled result.
    bus_a.out_ready = 1'b0;
    send(0, 2'd0, 32'd7, 32'd9, 32'd63);
    push_exp(0, 2'd3, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF);
    bus_a.in_valid = 1'b1; bus_a.in_op = 2'd3;
    bus_a.in_a = 32'hFFFFFFFD; bus_a.in_b = 32'h00000005;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus_a.out_valid && w < 20);
    check("L1 bp_valid_seen", bus_a.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("L1 bp_out_valid", bus_a.out_valid, 1);
      check("L1 bp_out_result", bus_a.out_result, 63);
      check("L1 bp_in_ready", bus_a.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("L1 bp_ready_next_cycle", bus_a.in_ready, 1);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    check("L1 bp_queued_accepted", bus_a.in_ready, 0);
    @(posedge clk); #1;
    wait_drain(0);
  endtask

  task automatic random_b();
    logic [1:0]  op;
    logic [31:0] a, b;
    rnd_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(3));
      a  = pick();
      b  = pick();
      send(1, op, a, b, ref_mul(op, a, b));
    end
    wait_drain(1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rnd_bp = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_op = '0; bus_a.in_a = '0; bus_a.in_b = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_op = '0; bus_b.in_a = '0; bus_b.in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check_idle("L1 ", bus_a.in_ready, bus_a.out_valid, en_a, bus_a.out_result, src1_a, src2_a);
    check_idle("L3 ", bus_b.in_ready, bus_b.out_valid, en_b, bus_b.out_result, src1_b, src2_b);
    @(posedge clk); #1;
    fork
      directed_a();
      random_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d checks made", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
